// File: rtl/vic_regs.sv
// VIC-style register file: CPU read/write port, raster counter, light pen
// capture, paddle sampling and decoded video/sound configuration outputs.
module vic_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [7:0]  hpos,
  input  logic        lp_trigger,
  input  logic [7:0]  pot_x,
  input  logic [7:0]  pot_y,
  output logic [6:0]  xorigin,
  output logic [7:0]  yorigin,
  output logic [6:0]  cols,
  output logic [6:0]  rows,
  output logic        chars8x16,
  output logic        inverted,
  output logic        interlace,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic [3:0]  aux_color,
  output logic [31:0] snd_freq,
  output logic [3:0]  snd_volume
);

  logic [7:0]  r0_q, r1_q, r2_q, r5_q, r14_q, r15_q;
  logic [6:0]  r3_q;
  logic [31:0] snd_q;
  logic [7:0]  lp_x_q, lp_y_q, pot_x_q, pot_y_q;
  logic [7:0]  cpu_dout_q;
  logic [8:0]  raster_q, raster_d;
  logic        phase_q, phase_d;
  logic        lp_armed_q, lp_armed_d;
  logic        lp_capture;
  logic [7:0]  rd_data;

  function automatic logic [15:0] vic_map(input logic [13:0] v);
    return {~v[13], 2'b00, v[12:0]};
  endfunction

  always_comb begin
    raster_d = raster_q;
    phase_d  = phase_q;
    if (frame_start) begin
      raster_d = 9'd0;
      phase_d  = 1'b0;
    end else if (line_start) begin
      phase_d = ~phase_q;
      if (phase_q && (raster_q != 9'h1FF))
        raster_d = raster_q + 9'd1;
    end
  end

  // A capture always disarms, even when frame_start arrives in the same cycle.
  assign lp_capture = lp_armed_q & lp_trigger;
  assign lp_armed_d = lp_capture ? 1'b0 : (frame_start ? 1'b1 : lp_armed_q);

  always_comb begin
    rd_data = 8'h00;
    case (cpu_addr)
      4'h0: rd_data = r0_q;
      4'h1: rd_data = r1_q;
      4'h2: rd_data = r2_q;
      4'h3: rd_data = {raster_q[0], r3_q};
      4'h4: rd_data = raster_q[8:1];
      4'h5: rd_data = r5_q;
      4'h6: rd_data = lp_x_q;
      4'h7: rd_data = lp_y_q;
      4'h8: rd_data = pot_x_q;
      4'h9: rd_data = pot_y_q;
      4'hA: rd_data = snd_q[7:0];
      4'hB: rd_data = snd_q[15:8];
      4'hC: rd_data = snd_q[23:16];
      4'hD: rd_data = snd_q[31:24];
      4'hE: rd_data = r14_q;
      4'hF: rd_data = r15_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r0_q       <= 8'h0C;
      r1_q       <= 8'h26;
      r2_q       <= 8'h96;
      r3_q       <= 7'h2E;
      r5_q       <= 8'hF0;
      r14_q      <= 8'h00;
      r15_q      <= 8'h1B;
      snd_q      <= 32'h0;
      lp_x_q     <= 8'h00;
      lp_y_q     <= 8'h00;
      pot_x_q    <= 8'h00;
      pot_y_q    <= 8'h00;
      cpu_dout_q <= 8'h00;
      raster_q   <= 9'd0;
      phase_q    <= 1'b0;
      lp_armed_q <= 1'b1;
    end else begin
      raster_q   <= raster_d;
      phase_q    <= phase_d;
      lp_armed_q <= lp_armed_d;
      if (lp_capture) begin
        lp_x_q <= hpos;
        lp_y_q <= raster_q[8:1];
      end
      if (frame_start) begin
        pot_x_q <= pot_x;
        pot_y_q <= pot_y;
      end
      if (cpu_cs && !cpu_we)
        cpu_dout_q <= rd_data;
      if (cpu_cs && cpu_we) begin
        case (cpu_addr)
          4'h0: r0_q <= cpu_din;
          4'h1: r1_q <= cpu_din;
          4'h2: r2_q <= cpu_din;
          4'h3: r3_q <= cpu_din[6:0];
          4'h5: r5_q <= cpu_din;
          4'hA: snd_q[7:0]   <= cpu_din;
          4'hB: snd_q[15:8]  <= cpu_din;
          4'hC: snd_q[23:16] <= cpu_din;
          4'hD: snd_q[31:24] <= cpu_din;
          4'hE: r14_q <= cpu_din;
          4'hF: r15_q <= cpu_din;
          default: ;
        endcase
      end
    end
  end

  assign cpu_dout       = cpu_dout_q;
  assign xorigin        = r0_q[6:0];
  assign interlace      = r0_q[7];
  assign yorigin        = r1_q;
  assign cols           = r2_q[6:0];
  assign rows           = {1'b0, r3_q[6:1]};
  assign chars8x16      = r3_q[0];
  assign screen_addr    = vic_map({r5_q[7:4], r2_q[7], 9'b0});
  assign char_rom_addr  = vic_map({r5_q[3:0], 10'b0});
  assign color_ram_addr = 16'h9400 | {6'b0, r2_q[7], 9'b0};
  assign aux_color      = r14_q[7:4];
  assign snd_volume     = r14_q[3:0];
  assign back_color     = r15_q[7:4];
  assign inverted       = r15_q[3];
  assign border_color   = r15_q[2:0];
  assign snd_freq       = snd_q;

endmodule

// File: tb/tb_vic_regs.sv
// Directed bench for vic_regs: a table of register accesses plus hand-written
// raster, light pen, paddle and reset sequences.
module tb_vic_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        line_start, frame_start, lp_trigger;
  logic [7:0]  hpos, pot_x, pot_y;
  logic [6:0]  xorigin, cols, rows;
  logic [7:0]  yorigin;
  logic        chars8x16, inverted, interlace;
  logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
  logic [2:0]  border_color;
  logic [3:0]  back_color, aux_color, snd_volume;
  logic [31:0] snd_freq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vic_regs dut (
    .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .line_start(line_start), .frame_start(frame_start), .hpos(hpos),
    .lp_trigger(lp_trigger), .pot_x(pot_x), .pot_y(pot_y),
    .xorigin(xorigin), .yorigin(yorigin), .cols(cols), .rows(rows),
    .chars8x16(chars8x16), .inverted(inverted), .interlace(interlace),
    .screen_addr(screen_addr), .char_rom_addr(char_rom_addr),
    .color_ram_addr(color_ram_addr), .border_color(border_color),
    .back_color(back_color), .aux_color(aux_color),
    .snd_freq(snd_freq), .snd_volume(snd_volume)
  );

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_cs = 1'b0;
    check(name, {24'h0, cpu_dout}, {24'h0, exp});
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] h);
    hpos = h; lp_trigger = 1'b1;
    tick();
    lp_trigger = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h0C};
    vecs[1]  = '{1'b0, 4'h1, 8'h00, 8'h26};
    vecs[2]  = '{1'b0, 4'h2, 8'h00, 8'h96};
    vecs[3]  = '{1'b0, 4'h3, 8'h00, 8'h2E};
    vecs[4]  = '{1'b0, 4'h5, 8'h00, 8'hF0};
    vecs[5]  = '{1'b0, 4'hF, 8'h00, 8'h1B};
    vecs[6]  = '{1'b0, 4'hE, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 4'h4, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 4'h0, 8'h85, 8'h85};
    vecs[9]  = '{1'b1, 4'h3, 8'hFF, 8'h7F};
    vecs[10] = '{1'b1, 4'h6, 8'hAB, 8'h00};
    vecs[11] = '{1'b1, 4'h8, 8'h55, 8'h00};
    vecs[12] = '{1'b1, 4'hA, 8'h11, 8'h11};
    vecs[13] = '{1'b1, 4'hD, 8'h44, 8'h44};

    reset = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_din = 8'h00;
    line_start = 1'b0; frame_start = 1'b0; lp_trigger = 1'b0;
    hpos = 8'h00; pot_x = 8'h00; pot_y = 8'h00;
    tick(); tick();
    reset = 1'b1;
    tick();

    check("rst_dout", {24'h0, cpu_dout}, 32'h0);
    check("rst_xorigin", {25'h0, xorigin}, 32'd12);
    check("rst_yorigin", {24'h0, yorigin}, 32'd38);
    check("rst_cols", {25'h0, cols}, 32'd22);
    check("rst_rows", {25'h0, rows}, 32'd23);
    check("rst_screen", {16'h0, screen_addr}, 32'h1E00);
    check("rst_charrom", {16'h0, char_rom_addr}, 32'h8000);
    check("rst_colram", {16'h0, color_ram_addr}, 32'h9600);
    check("rst_colors", {23'h0, back_color, inverted, border_color}, {23'h0, 4'd1, 1'b1, 3'd3});

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    wr(4'hB, 8'h22);
    wr(4'hC, 8'h33);
    check("snd_freq", snd_freq, 32'h44332211);
    check("r0_fields", {24'h0, interlace, xorigin}, 32'h85);
    check("r3_fields", {24'h0, rows, chars8x16}, {24'h0, 7'd63, 1'b1});
    wr(4'hE, 8'hA7);
    check("r14_fields", {24'h0, aux_color, snd_volume}, 32'hA7);

    wr(4'h5, 8'hCC);
    wr(4'h2, 8'h16);
    check("map_screen", {16'h0, screen_addr}, 32'h1000);
    check("map_charrom", {16'h0, char_rom_addr}, 32'h1000);
    check("map_colram", {16'h0, color_ram_addr}, 32'h9400);
    check("map_cols", {25'h0, cols}, 32'd22);

    frame();
    lines(7);
    rd_check("raster3_r4", 4'h4, 8'h01);
    rd_check("raster3_r3", 4'h3, 8'hFF);
    wr(4'h4, 8'hFF);
    rd_check("r4_readonly", 4'h4, 8'h01);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h4; line_start = 1'b1;
    tick();
    cpu_cs = 1'b0; line_start = 1'b0;
    check("raster_collision", {24'h0, cpu_dout}, 32'h01);
    rd_check("raster4_r4", 4'h4, 8'h02);

    frame();
    lines(100);
    rd_check("raster50", 4'h4, 8'h19);
    frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    rd_check("coinc_r4", 4'h4, 8'h00);
    rd_check("coinc_r3", 4'h3, 8'h7F);
    lines(1);
    rd_check("coinc_phase_a", 4'h3, 8'h7F);
    lines(1);
    rd_check("coinc_phase_b", 4'h3, 8'hFF);

    frame();
    lines(1100);
    rd_check("sat_r4", 4'h4, 8'hFF);
    rd_check("sat_r3", 4'h3, 8'hFF);

    frame();
    lines(40);
    trigger(8'h40);
    rd_check("lp_x1", 4'h6, 8'h40);
    rd_check("lp_y1", 4'h7, 8'h0A);
    lines(4);
    trigger(8'h50);
    rd_check("lp_once", 4'h6, 8'h40);
    rd_check("lp_once_y", 4'h7, 8'h0A);
    frame();
    trigger(8'h50);
    rd_check("lp_rearm", 4'h6, 8'h50);
    rd_check("lp_rearm_y", 4'h7, 8'h00);

    frame();
    lines(10);
    frame_start = 1'b1; hpos = 8'h33; lp_trigger = 1'b1;
    tick();
    frame_start = 1'b0; lp_trigger = 1'b0;
    trigger(8'h44);
    rd_check("lp_coinc_x", 4'h6, 8'h33);
    rd_check("lp_coinc_y", 4'h7, 8'h02);

    pot_x = 8'h5A; pot_y = 8'hA5;
    frame();
    rd_check("pot_x", 4'h8, 8'h5A);
    rd_check("pot_y", 4'h9, 8'hA5);
    pot_x = 8'h77;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h8; frame_start = 1'b1;
    tick();
    cpu_cs = 1'b0; frame_start = 1'b0;
    check("pot_collision", {24'h0, cpu_dout}, 32'h5A);
    rd_check("pot_new", 4'h8, 8'h77);

    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 4'hF; cpu_din = 8'h08; reset = 1'b0;
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0; reset = 1'b1;
    tick();
    check("rst_wr_back", {28'h0, back_color}, 32'd1);
    check("rst_wr_border", {29'h0, border_color}, 32'd3);
    check("rst2_dout", {24'h0, cpu_dout}, 32'h0);
    rd_check("rst2_pot", 4'h8, 8'h00);
    rd_check("rst2_raster", 4'h4, 8'h00);
    trigger(8'h21);
    rd_check("rst2_lp_armed", 4'h6, 8'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
